// File: rtl/complex_exe_unit.sv
// Multi-cycle complex-number execution unit: ADD/SUB in one EXEC cycle,
// MUL and CMUL (a * conj(b)) in four EXEC cycles sharing one W x W multiplier.
module complex_exe_unit #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         start,
   input  logic         flush,
   input  logic [1:0]   op,
   input  logic [W-1:0] a_re,
   input  logic [W-1:0] a_im,
   input  logic [W-1:0] b_re,
   input  logic [W-1:0] b_im,
   input  logic [3:0]   wr_reg1_in,
   input  logic [3:0]   wr_reg2_in,
   input  logic         reg_write_en_C_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] res_re,
   output logic [W-1:0] res_im,
   output logic [3:0]   wr_reg1,
   output logic [3:0]   wr_reg2,
   output logic         reg_write_en_C
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_CMUL = 2'b11;

   state_t       state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [1:0]   op_q, op_d;
   logic [W-1:0] aRe_q, aRe_d, aIm_q, aIm_d, bRe_q, bRe_d, bIm_q, bIm_d;
   logic [W-1:0] accRe_q, accRe_d, accIm_q, accIm_d;
   logic [W-1:0] resRe_q, resRe_d, resIm_q, resIm_d;
   logic [3:0]   wr1_q, wr1_d, wr2_q, wr2_d;
   logic         we_q, we_d;
   logic         isCmul;
   logic [W-1:0] mulX, mulY, prod;

   assign isCmul = (op_q == OP_CMUL);

   // Shared multiplier: the step counter picks which cross product feeds it.
   always_comb begin
      mulX = aRe_q;
      mulY = bRe_q;
      case (cnt_q)
         2'd0: begin mulX = aRe_q; mulY = bRe_q; end
         2'd1: begin mulX = aIm_q; mulY = bIm_q; end
         2'd2: begin mulX = isCmul ? aIm_q : aRe_q; mulY = isCmul ? bRe_q : bIm_q; end
         default: begin mulX = isCmul ? aRe_q : aIm_q; mulY = isCmul ? bIm_q : bRe_q; end
      endcase
      prod = mulX * mulY;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      aRe_d   = aRe_q;
      aIm_d   = aIm_q;
      bRe_d   = bRe_q;
      bIm_d   = bIm_q;
      accRe_d = accRe_q;
      accIm_d = accIm_q;
      resRe_d = resRe_q;
      resIm_d = resIm_q;
      wr1_d   = wr1_q;
      wr2_d   = wr2_q;
      we_d    = we_q;
      unique case (state_q)
         IDLE: begin
            if (start && !flush) begin
               state_d = EXEC;
               cnt_d   = 2'd0;
               op_d    = op;
               aRe_d   = a_re;
               aIm_d   = a_im;
               bRe_d   = b_re;
               bIm_d   = b_im;
               wr1_d   = wr_reg1_in;
               wr2_d   = wr_reg2_in;
               we_d    = reg_write_en_C_in;
            end
         end
         EXEC: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = 2'd0;
            end else if (!op_q[1]) begin
               resRe_d = (op_q == OP_SUB) ? aRe_q - bRe_q : aRe_q + bRe_q;
               resIm_d = (op_q == OP_SUB) ? aIm_q - bIm_q : aIm_q + bIm_q;
               state_d = DONE;
            end else begin
               // Partial sums live in acc*; the result registers change only on the last step.
               cnt_d = cnt_q + 2'd1;
               case (cnt_q)
                  2'd0: accRe_d = prod;
                  2'd1: accRe_d = isCmul ? accRe_q + prod : accRe_q - prod;
                  2'd2: accIm_d = prod;
                  default: begin
                     resRe_d = accRe_q;
                     resIm_d = isCmul ? accIm_q - prod : accIm_q + prod;
                     state_d = DONE;
                  end
               endcase
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         aRe_q   <= '0;
         aIm_q   <= '0;
         bRe_q   <= '0;
         bIm_q   <= '0;
         accRe_q <= '0;
         accIm_q <= '0;
         resRe_q <= '0;
         resIm_q <= '0;
         wr1_q   <= '0;
         wr2_q   <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         aRe_q   <= aRe_d;
         aIm_q   <= aIm_d;
         bRe_q   <= bRe_d;
         bIm_q   <= bIm_d;
         accRe_q <= accRe_d;
         accIm_q <= accIm_d;
         resRe_q <= resRe_d;
         resIm_q <= resIm_d;
         wr1_q   <= wr1_d;
         wr2_q   <= wr2_d;
         we_q    <= we_d;
      end
   end

   // A flush arriving in DONE kills the pulse in that same cycle.
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE) && !flush;
   assign reg_write_en_C = done && we_q;
   assign res_re         = resRe_q;
   assign res_im         = resIm_q;
   assign wr_reg1        = wr1_q;
   assign wr_reg2        = wr2_q;

endmodule

// File: tb/tb_complex_exe_unit.sv
// Self-checking bench for complex_exe_unit: directed scenarios plus random ops
// compared against plain complex arithmetic.
module tb_complex_exe_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_b, start, flush;
   logic [1:0]   op;
   logic [W-1:0] a_re, a_im, b_re, b_im;
   logic [3:0]   wr_reg1_in, wr_reg2_in;
   logic         reg_write_en_C_in;
   logic         busy, done, reg_write_en_C;
   logic [W-1:0] res_re, res_im;
   logic [3:0]   wr_reg1, wr_reg2;

   int testsRun = 0;
   int testsFailed = 0;
   int doneSeen = 0;
   int doneBefore;

   complex_exe_unit #(.W(W)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .flush(flush), .op(op),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .wr_reg1_in(wr_reg1_in), .wr_reg2_in(wr_reg2_in),
      .reg_write_en_C_in(reg_write_en_C_in),
      .busy(busy), .done(done), .res_re(res_re), .res_im(res_im),
      .wr_reg1(wr_reg1), .wr_reg2(wr_reg2), .reg_write_en_C(reg_write_en_C)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) doneSeen++;

   task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference: textbook complex arithmetic, truncated to W bits.
   function automatic void model(input logic [1:0] o, input logic [W-1:0] ar, ai, br, bi,
                                 output logic [W-1:0] re, output logic [W-1:0] im);
      case (o)
         2'd0: begin re = ar + br; im = ai + bi; end
         2'd1: begin re = ar - br; im = ai - bi; end
         2'd2: begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
         default: begin re = ar * br + ai * bi; im = ai * br - ar * bi; end
      endcase
   endfunction

   task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] ar, ai, br, bi,
                                input logic [3:0] d1, d2, input logic we, input bit pokeStart);
      logic [W-1:0] expRe, expIm;
      int lat, obsLat;
      model(o, ar, ai, br, bi, expRe, expIm);
      lat = o[1] ? 5 : 2;
      @(negedge clk);
      op = o; a_re = ar; a_im = ai; b_re = br; b_im = bi;
      wr_reg1_in = d1; wr_reg2_in = d2; reg_write_en_C_in = we;
      start = 1'b1; flush = 1'b0;
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); a_re = $urandom; a_im = $urandom; b_re = $urandom; b_im = $urandom;
      wr_reg1_in = 4'($urandom); wr_reg2_in = 4'($urandom); reg_write_en_C_in = 1'($urandom);
      obsLat = 0;
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clk);
         if (done === 1'b1) begin
            obsLat = k;
            break;
         end
         checkOutput("busyExec", busy, 1);
         checkOutput("wenExec", reg_write_en_C, 0);
         if (pokeStart) start = (k == 2);
      end
      start = 1'b0;
      checkOutput("latency", obsLat, lat);
      if (obsLat != 0) begin
         checkOutput("busyDone", busy, 1);
         checkOutput("resRe", res_re, expRe);
         checkOutput("resIm", res_im, expIm);
         checkOutput("wrReg1", wr_reg1, d1);
         checkOutput("wrReg2", wr_reg2, d2);
         checkOutput("wenDone", reg_write_en_C, we);
      end
      @(negedge clk);
      checkOutput("donePulse", done, 0);
      checkOutput("busyIdle", busy, 0);
      checkOutput("wenIdle", reg_write_en_C, 0);
      checkOutput("holdRe", res_re, expRe);
      checkOutput("holdIm", res_im, expIm);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Busy"}, busy, 0);
      checkOutput({tag, "Done"}, done, 0);
      checkOutput({tag, "Wen"}, reg_write_en_C, 0);
      checkOutput({tag, "Re"}, res_re, 0);
      checkOutput({tag, "Im"}, res_im, 0);
      checkOutput({tag, "Wr1"}, wr_reg1, 0);
      checkOutput({tag, "Wr2"}, wr_reg2, 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb, rc, rd;
      rst_b = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0;
      wr_reg1_in = '0; wr_reg2_in = '0; reg_write_en_C_in = 1'b0;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst_b = 1'b1;

      applyStimulus(2'd0, 32'd3, 32'd4, 32'd5, 32'hFFFF_FFFE, 4'd2, 4'd3, 1'b1, 1'b0);
      applyStimulus(2'd2, 32'd3, 32'd4, 32'd5, 32'hFFFF_FFFE, 4'd5, 4'd6, 1'b1, 1'b0);
      applyStimulus(2'd0, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, 4'd1, 4'd9, 1'b0, 1'b0);

      doneBefore = doneSeen;
      applyStimulus(2'd3, 32'd3, 32'd4, 32'd5, 32'hFFFF_FFFE, 4'd7, 4'd8, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      #1;
      checkOutput("ignoredStart", doneSeen - doneBefore, 1);

      // Flush a MUL during step 2; prior CMUL result must survive.
      doneBefore = doneSeen;
      @(negedge clk);
      op = 2'd2; a_re = $urandom; a_im = $urandom; b_re = $urandom; b_im = $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      flush = 1'b1;
      checkOutput("flushDone", done, 0);
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flushBusy", busy, 0);
      checkOutput("flushRe", res_re, 32'd7);
      checkOutput("flushIm", res_im, 32'd26);
      repeat (6) @(negedge clk);
      #1;
      checkOutput("flushNoDone", doneSeen - doneBefore, 0);
      applyStimulus(2'd1, 32'd1, 32'd1, 32'd2, 32'd3, 4'd4, 4'd5, 1'b1, 1'b0);

      doneBefore = doneSeen;
      @(negedge clk);
      op = 2'd0; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      checkOutput("startFlushBusy", busy, 0);
      repeat (4) @(negedge clk);
      #1;
      checkOutput("startFlushNoDone", doneSeen - doneBefore, 0);

      // Reset lands in MUL step 1.
      doneBefore = doneSeen;
      @(negedge clk);
      op = 2'd2; a_re = 32'd9; a_im = 32'd8; b_re = 32'd7; b_im = 32'd6;
      wr_reg1_in = 4'd11; wr_reg2_in = 4'd12; reg_write_en_C_in = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      checkAllZero("midReset");
      @(negedge clk);
      rst_b = 1'b1;
      #1;
      checkOutput("resetNoDone", doneSeen - doneBefore, 0);
      applyStimulus(2'd0, 32'd1, 32'd1, 32'd1, 32'd1, 4'd14, 4'd15, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            ra = 32'h7FFF_FFFF; rc = 32'h8000_0000;
         end
         applyStimulus(2'($urandom), ra, rb, rc, rd, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/complex_exe_unit.md
COMPLEX_EXE_UNIT -- requirements
Module: complex_exe_unit

Interface
REQ-001 Parameter: W, 32, operand/result component width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_b  input  1  asynchronous active-low reset.
REQ-004 start  input  1  complex op presented by ID/EXE register (complex & valid).
REQ-005 flush  input  1  synchronous kill of in-flight op.
REQ-006 op  input  2  00 ADD, 01 SUB, 10 MUL, 11 CMUL (a times conj(b)).
REQ-007 a_re, a_im, b_re, b_im  input  W each  two's-complement operand components.
REQ-008 wr_reg1_in, wr_reg2_in  input  4 each  complex destination registers (real, imaginary).
REQ-009 reg_write_en_C_in  input  1  writeback enable for the op.
REQ-010 busy  output  1  stall request to front end; high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle result-valid pulse.
REQ-012 res_re, res_im  output  W each  registered result components.
REQ-013 wr_reg1, wr_reg2  output  4 each  destinations captured at start.
REQ-014 reg_write_en_C  output  1  equals done AND captured reg_write_en_C_in.

Function
REQ-015 States SHALL be IDLE, EXEC, DONE; busy = (state != IDLE).
REQ-016 In IDLE with start=1 and flush=0, the unit SHALL capture op, operands, destinations and write enable at the rising edge and enter EXEC.
REQ-017 start SHALL be ignored while busy; no queuing.
REQ-018 ADD/SUB SHALL spend one cycle in EXEC: res_re = a_re +/- b_re, res_im = a_im +/- b_im.
REQ-019 MUL/CMUL SHALL spend four cycles in EXEC using one W x W multiplier, 2-bit step counter 0..3, one partial product per cycle.
REQ-020 MUL steps: 0 re = a_re*b_re; 1 re -= a_im*b_im; 2 im = a_re*b_im; 3 im += a_im*b_re.
REQ-021 CMUL steps: 0 re = a_re*b_re; 1 re += a_im*b_im; 2 im = a_im*b_re; 3 im -= a_re*b_im.
REQ-022 All arithmetic SHALL keep the low W bits (mod 2^W wrap); no overflow flag, no saturation.
REQ-023 After the last EXEC cycle the unit SHALL enter DONE, assert done for exactly one cycle, then return to IDLE.
REQ-024 Latency from start edge to done high: ADD/SUB 2 cycles, MUL/CMUL 5 cycles; next start accepted the cycle after done.
REQ-025 res_re/res_im SHALL update only on completion of an op and otherwise hold the last completed result.
REQ-026 wr_reg1/wr_reg2 SHALL hold captured values until the next accepted start.
REQ-027 flush=1 in EXEC or DONE SHALL return to IDLE at the next edge with done and reg_write_en_C low that cycle and res_re/res_im unchanged.
REQ-028 flush=1 together with start in IDLE SHALL suppress the start.
REQ-029 Step counter SHALL clear on every accepted start and on flush.

Reset
REQ-030 rst_b low SHALL immediately force state IDLE, counter 0, busy=0, done=0, reg_write_en_C=0, res_re=res_im=0, wr_reg1=wr_reg2=0, all captured operands 0.
REQ-031 Reset mid-operation SHALL abandon the op with no done pulse; the first start after release SHALL be accepted normally.

Verification
REQ-032 ADD a=(3,4), b=(5,-2), reg_write_en_C_in=1, dests 2/3 -> done at cycle 2, res=(8,2), wr_reg1=2, wr_reg2=3, reg_write_en_C pulse 1 cycle.
REQ-033 MUL a=(3,4), b=(5,-2) -> busy high 4 EXEC + 1 DONE cycles, done at cycle 5, res=(23,14).
REQ-034 CMUL a=(3,4), b=(5,-2) -> res=(7,26); second start asserted during busy ignored, no second done.
REQ-035 ADD a=(0x7FFFFFFF,0), b=(1,0) -> res_re=0x80000000 (wrap), res_im=0.
REQ-036 MUL started, flush at EXEC step 2 -> IDLE next edge, no done, res keeps prior (7,26); new SUB (1,1)-(2,3) -> res=(-1,-2).
REQ-037 rst_b low during MUL step 1 -> all outputs 0 immediately, busy=0; after release, ADD (1,1)+(1,1) -> res=(2,2) at cycle 2.
